// File: rtl/alarm_fsm.sv
// Anti-theft alarm controller.
// Sequences arm / trigger / siren / disarm from the ignition and door inputs.
// Acts as the initiator towards a shared countdown timer: it loads an interval
// on value, pulses start_timer, and later consumes the timer's expired level.
module alarm_fsm #(
  parameter int WIDTH = 4
) (
  input  logic             clock_25mhz,
  input  logic             reset_n,
  input  logic             ignition,
  input  logic             door_driver,
  input  logic             door_pass,
  input  logic             one_hz_enable,
  input  logic [WIDTH-1:0] t_arm_delay,
  input  logic [WIDTH-1:0] t_driver_delay,
  input  logic [WIDTH-1:0] t_pass_delay,
  input  logic [WIDTH-1:0] t_alarm_on,
  input  logic             expired,
  output logic             start_timer,
  output logic [WIDTH-1:0] value,
  output logic             siren_on,
  output logic             status_led,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    SOUND      = 3'd2,
    ALARM_HOLD = 3'd3,
    DISARMED   = 3'd4,
    WAIT_OPEN  = 3'd5,
    WAIT_CLOSE = 3'd6,
    ARM_DELAY  = 3'd7
  } alarmState_t;

  alarmState_t      r_state;
  alarmState_t      w_nextState;
  logic             r_start;
  logic             r_guardDly;
  logic [WIDTH-1:0] r_value;
  logic             r_siren;
  logic             r_led;

  logic             w_expValid;
  logic             w_anyDoor;
  logic             w_start;
  logic [WIDTH-1:0] w_value;
  logic             w_siren;
  logic             w_led;

  // The timer only drops expired one cycle after it sees start_timer, so the
  // level is untrustworthy on the pulse cycle and the cycle after it.
  assign w_expValid = expired & ~r_start & ~r_guardDly;
  assign w_anyDoor  = door_driver | door_pass;

  assign start_timer = r_start;
  assign value       = r_value;
  assign siren_on    = r_siren;
  assign status_led  = r_led;
  assign state       = r_state;

  // Next-state and next-output decode; ignition beats expired beats doors,
  // and expired is only acted on in the three timing states.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_value     = r_value;
    w_siren     = 1'b0;
    w_led       = 1'b0;

    if (ignition) begin
      w_nextState = DISARMED;
    end else begin
      case (r_state)
        ARMED: begin
          if (door_driver) begin
            w_nextState = TRIGGERED;
            w_start     = 1'b1;
            w_value     = t_driver_delay;
          end else if (door_pass) begin
            w_nextState = TRIGGERED;
            w_start     = 1'b1;
            w_value     = t_pass_delay;
          end
        end
        TRIGGERED: begin
          if (w_expValid) w_nextState = SOUND;
        end
        SOUND: begin
          if (!w_anyDoor) begin
            w_nextState = ALARM_HOLD;
            w_start     = 1'b1;
            w_value     = t_alarm_on;
          end
        end
        ALARM_HOLD: begin
          if (w_expValid)     w_nextState = ARMED;
          else if (w_anyDoor) w_nextState = SOUND;
        end
        DISARMED: begin
          w_nextState = WAIT_OPEN;
        end
        WAIT_OPEN: begin
          if (door_driver) w_nextState = WAIT_CLOSE;
        end
        WAIT_CLOSE: begin
          if (!w_anyDoor) begin
            w_nextState = ARM_DELAY;
            w_start     = 1'b1;
            w_value     = t_arm_delay;
          end
        end
        ARM_DELAY: begin
          if (w_expValid)     w_nextState = ARMED;
          else if (w_anyDoor) w_nextState = WAIT_CLOSE;
        end
        default: begin
          w_nextState = ARMED;
        end
      endcase
    end

    w_siren = (w_nextState == SOUND) || (w_nextState == ALARM_HOLD);

    case (w_nextState)
      TRIGGERED, SOUND, ALARM_HOLD: w_led = 1'b1;
      ARMED:   w_led = (r_state == ARMED) ? (r_led ^ one_hz_enable) : 1'b0;
      default: w_led = 1'b0;
    endcase
  end

  // State and output registers; reset lands in ARMED with everything quiet.
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARMED;
      r_start    <= 1'b0;
      r_guardDly <= 1'b0;
      r_value    <= '0;
      r_siren    <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_start    <= w_start;
      r_guardDly <= r_start;
      r_value    <= w_value;
      r_siren    <= w_siren;
      r_led      <= w_led;
    end
  end

endmodule

// File: tb/tb_alarm_fsm.sv
// Directed table-driven bench for alarm_fsm; the timer is played by the bench
// driving expired by hand.
module tb_alarm_fsm;

  logic       clk;
  logic       rstN;
  logic       ign;
  logic       doorDrv;
  logic       doorPass;
  logic       oneHz;
  logic [3:0] tArm;
  logic [3:0] tDrv;
  logic [3:0] tPass;
  logic [3:0] tAlarm;
  logic       exp;
  logic       startTimer;
  logic [3:0] value;
  logic       siren;
  logic       led;
  logic [2:0] state;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct packed {
    logic       ign;
    logic       dd;
    logic       dp;
    logic       hz;
    logic       exp;
    logic       eStart;
    logic [3:0] eValue;
    logic       eSiren;
    logic       eLed;
    logic [2:0] eState;
  } vec_t;

  vec_t vecs[$];

  alarm_fsm #(.WIDTH(4)) dut (
    .clock_25mhz   (clk),
    .reset_n       (rstN),
    .ignition      (ign),
    .door_driver   (doorDrv),
    .door_pass     (doorPass),
    .one_hz_enable (oneHz),
    .t_arm_delay   (tArm),
    .t_driver_delay(tDrv),
    .t_pass_delay  (tPass),
    .t_alarm_on    (tAlarm),
    .expired       (exp),
    .start_timer   (startTimer),
    .value         (value),
    .siren_on      (siren),
    .status_led    (led),
    .state         (state)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic i, input logic d, input logic p,
                              input logic h, input logic e, input logic es,
                              input logic [3:0] ev, input logic esi,
                              input logic el, input logic [2:0] est);
    vec_t v;
    v = '{i, d, p, h, e, es, ev, esi, el, est};
    return v;
  endfunction

  task automatic checkOutput(input string name, input vec_t v);
    vecCount++;
    if (startTimer !== v.eStart || value !== v.eValue || siren !== v.eSiren ||
        led !== v.eLed || state !== v.eState) begin
      missCount++;
      $display("[TB] FAIL %s: got start=%0b value=%0d siren=%0b led=%0b state=%0d, expected start=%0b value=%0d siren=%0b led=%0b state=%0d",
               name, startTimer, value, siren, led, state,
               v.eStart, v.eValue, v.eSiren, v.eLed, v.eState);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ign      = v.ign;
    doorDrv  = v.dd;
    doorPass = v.dp;
    oneHz    = v.hz;
    exp      = v.exp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             ign dd dp hz exp | st val sir led state
    vecs.push_back(mk(0,0,1,0,0, 1,4'd6,0,1,3'd1)); // pass door -> TRIGGERED, value 6
    vecs.push_back(mk(0,0,0,0,1, 0,4'd6,0,1,3'd1)); // expired on pulse cycle ignored
    vecs.push_back(mk(0,0,0,0,1, 0,4'd6,0,1,3'd1)); // expired cycle after pulse ignored
    vecs.push_back(mk(0,0,0,0,1, 0,4'd6,1,1,3'd2)); // expired -> SOUND
    vecs.push_back(mk(0,1,0,0,1, 0,4'd6,1,1,3'd2)); // door open, stale expired ignored
    vecs.push_back(mk(0,0,0,0,0, 1,4'd4,1,1,3'd3)); // doors closed -> HOLD, value 4
    vecs.push_back(mk(0,0,1,0,0, 0,4'd4,1,1,3'd2)); // reopen -> SOUND, no pulse
    vecs.push_back(mk(0,0,0,0,0, 1,4'd4,1,1,3'd3)); // close again -> new pulse
    vecs.push_back(mk(0,0,0,0,0, 0,4'd4,1,1,3'd3));
    vecs.push_back(mk(0,0,0,0,1, 0,4'd4,1,1,3'd3)); // guard cycle
    vecs.push_back(mk(0,1,0,0,1, 0,4'd4,0,0,3'd0)); // expired beats door -> ARMED
    vecs.push_back(mk(0,0,0,1,1, 0,4'd4,0,1,3'd0)); // led toggle, stale expired ignored
    vecs.push_back(mk(0,0,0,0,0, 0,4'd4,0,1,3'd0));
    vecs.push_back(mk(0,0,0,1,0, 0,4'd4,0,0,3'd0));
    vecs.push_back(mk(0,0,0,1,0, 0,4'd4,0,1,3'd0));
    vecs.push_back(mk(0,1,1,0,0, 1,4'd8,0,1,3'd1)); // both doors -> driver value wins
    vecs.push_back(mk(0,0,0,0,0, 0,4'd8,0,1,3'd1));
    vecs.push_back(mk(0,0,0,0,0, 0,4'd8,0,1,3'd1));
    vecs.push_back(mk(0,1,0,0,1, 0,4'd8,1,1,3'd2)); // expired -> SOUND, door ignored
    vecs.push_back(mk(0,1,0,0,0, 0,4'd8,1,1,3'd2));
    vecs.push_back(mk(1,1,0,0,0, 0,4'd8,0,0,3'd4)); // ignition in SOUND -> DISARMED
    vecs.push_back(mk(1,0,0,0,1, 0,4'd8,0,0,3'd4));
    vecs.push_back(mk(0,0,0,0,0, 0,4'd8,0,0,3'd5)); // ignition off -> WAIT_OPEN
    vecs.push_back(mk(0,0,1,0,0, 0,4'd8,0,0,3'd5)); // passenger door not enough
    vecs.push_back(mk(0,1,0,0,0, 0,4'd8,0,0,3'd6)); // driver door -> WAIT_CLOSE
    vecs.push_back(mk(0,1,0,0,0, 0,4'd8,0,0,3'd6));
    vecs.push_back(mk(0,0,0,0,0, 1,4'd3,0,0,3'd7)); // closed -> ARM_DELAY, value 3
    vecs.push_back(mk(0,0,1,0,0, 0,4'd3,0,0,3'd6)); // passenger opens -> WAIT_CLOSE
    vecs.push_back(mk(0,0,0,0,0, 1,4'd3,0,0,3'd7)); // closed -> new pulse
    vecs.push_back(mk(0,0,0,0,0, 0,4'd3,0,0,3'd7));
    vecs.push_back(mk(0,0,0,0,1, 0,4'd3,0,0,3'd7)); // guard cycle
    vecs.push_back(mk(0,0,0,0,1, 0,4'd3,0,0,3'd0)); // expired -> ARMED
    vecs.push_back(mk(0,1,0,0,0, 1,4'd8,0,1,3'd1)); // driver door -> TRIGGERED
    vecs.push_back(mk(0,0,0,0,0, 0,4'd8,0,1,3'd1));
    vecs.push_back(mk(0,0,0,0,0, 0,4'd8,0,1,3'd1));
    vecs.push_back(mk(1,0,0,0,1, 0,4'd8,0,0,3'd4)); // ignition beats expired

    tArm = 4'd3; tDrv = 4'd8; tPass = 4'd6; tAlarm = 4'd4;
    ign = 0; doorDrv = 0; doorPass = 0; oneHz = 0; exp = 0;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", mk(0,0,0,0,0, 0,4'd0,0,0,3'd0));
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d", i), vecs[i]);
    end

    // Zero interval is passed through, then async reset mid-SOUND.
    tPass = 4'd0;
    rstN = 1'b0;
    #1;
    checkOutput("reset2", mk(0,0,0,0,0, 0,4'd0,0,0,3'd0));
    ign = 0; exp = 0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(mk(0,0,1,0,0, 1,4'd0,0,1,3'd1));
    checkOutput("zeroValue", mk(0,0,1,0,0, 1,4'd0,0,1,3'd1));
    applyStimulus(mk(0,0,0,0,0, 0,4'd0,0,1,3'd1));
    applyStimulus(mk(0,0,0,0,0, 0,4'd0,0,1,3'd1));
    applyStimulus(mk(0,0,0,0,1, 0,4'd0,1,1,3'd2));
    checkOutput("zeroSound", mk(0,0,0,0,1, 0,4'd0,1,1,3'd2));
    applyStimulus(mk(0,1,0,0,0, 0,4'd0,1,1,3'd2));
    checkOutput("holdSound", mk(0,1,0,0,0, 0,4'd0,1,1,3'd2));
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncReset", mk(0,0,0,0,0, 0,4'd0,0,0,3'd0));
    #3;
    rstN = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
